// File: rtl/ram_scan_ctrl_pkg.sv
// ============================================================================
// Module : ram_scan_ctrl_pkg
// Brief  : Shared scan-mode encoding and default sizing for the RAM scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        AUTO  = 2'b00,
        PAUSE = 2'b01,
        STEP  = 2'b10,
        SWEEP = 2'b11
    } scan_mode_t;

    localparam int C_DATA_W_DEFAULT      = 3;
    localparam int C_ADDR_W_DEFAULT      = 5;
    localparam int C_TICK_CYCLES_DEFAULT = 50000000;

endpackage

`default_nettype wire

// File: rtl/ram_scan_ctrl_tick.sv
// ============================================================================
// Module : tick_div
// Brief  : Free-running divider producing a one-cycle tick every TICK_CYCLES.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tick_div
    import ram_scan_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES = C_TICK_CYCLES_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic Reset_n,
    input  logic En,
    input  logic Restart,
    output logic Tick
);

    localparam int              CW     = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0]   C_LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == C_LAST);
    // A restart cycle never emits a tick, so a Clear always wins over an advance
    assign Tick      = En & ~Restart & w_at_last;

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (Restart || !En || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_scan_ctrl.sv
// ============================================================================
// Module : ram_scan_ctrl
// Brief  : Dual-port RAM with a mode-controlled scanning read address.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_scan_ctrl
    import ram_scan_ctrl_pkg::*;
#(
    parameter int DATA_W      = C_DATA_W_DEFAULT,
    parameter int ADDR_W      = C_ADDR_W_DEFAULT,
    parameter int TICK_CYCLES = C_TICK_CYCLES_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              Reset_n,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [1:0]        Mode,
    input  logic              Step,
    input  logic              Clear,
    output logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              Done
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = '1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    scan_mode_t        w_mode;
    scan_mode_t        r_mode;
    logic              r_step_q;
    logic              r_step_qq;
    logic              r_addr_chg;

    logic              w_mode_chg;
    logic              w_tick_en;
    logic              w_tick_restart;
    logic              w_tick;
    logic              w_step_rise;
    logic              w_adv;
    logic              w_chg;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_done_nxt;

    assign w_mode         = scan_mode_t'(Mode);
    assign w_mode_chg     = (w_mode != r_mode);
    assign w_tick_en      = (w_mode == AUTO) || (w_mode == SWEEP);
    assign w_tick_restart = Clear | w_mode_chg;
    assign w_step_rise    = r_step_q & ~r_step_qq;

    tick_div #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_div (
        .CLOCK_50 (CLOCK_50),
        .Reset_n  (Reset_n),
        .En       (w_tick_en),
        .Restart  (w_tick_restart),
        .Tick     (w_tick)
    );

    always_comb begin
        w_adv      = 1'b0;
        w_addr_nxt = RdAddr;
        w_done_nxt = Done & (w_mode == SWEEP);
        case (w_mode)
            AUTO:    w_adv = w_tick;
            STEP:    w_adv = w_step_rise;
            SWEEP:   w_adv = w_tick & ~Done;
            default: w_adv = 1'b0;
        endcase
        if (Clear) begin
            w_addr_nxt = '0;
            w_done_nxt = 1'b0;
        end else if (w_adv) begin
            if ((w_mode == SWEEP) && (RdAddr == C_ADDR_LAST)) begin
                w_done_nxt = 1'b1;
            end else begin
                w_addr_nxt = RdAddr + 1'b1;
            end
        end
        w_chg = (w_addr_nxt != RdAddr);
    end

    // Array carries no reset so it can map onto block RAM
    always_ff @(posedge CLOCK_50) begin
        if (WrEn) begin
            r_mem[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            RdAddr     <= '0;
            RdData     <= '0;
            RdValid    <= 1'b0;
            Done       <= 1'b0;
            r_mode     <= AUTO;
            r_step_q   <= 1'b0;
            r_step_qq  <= 1'b0;
            r_addr_chg <= 1'b0;
        end else begin
            RdAddr     <= w_addr_nxt;
            RdData     <= (WrEn && (WrAddr == RdAddr)) ? WrData : r_mem[RdAddr];
            // Valid lines up with the first cycle RdData shows the new address
            RdValid    <= r_addr_chg;
            r_addr_chg <= w_chg;
            Done       <= w_done_nxt;
            r_mode     <= w_mode;
            r_step_q   <= Step;
            r_step_qq  <= r_step_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_scan_ctrl.sv
// ============================================================================
// Module : tb_ram_scan_ctrl
// Brief  : Directed self-checking bench for ram_scan_ctrl (4-cycle tick, 8 words).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_scan_ctrl;

    localparam int DW = 3;
    localparam int AW = 3;
    localparam int TC = 4;

    logic          CLOCK_50 = 1'b0;
    logic          Reset_n  = 1'b0;
    logic          WrEn     = 1'b0;
    logic [AW-1:0] WrAddr   = '0;
    logic [DW-1:0] WrData   = '0;
    logic [1:0]    Mode     = 2'b01;
    logic          Step     = 1'b0;
    logic          Clear    = 1'b0;
    logic [AW-1:0] RdAddr;
    logic [DW-1:0] RdData;
    logic          RdValid;
    logic          Done;

    int checks = 0;
    int errors = 0;

    ram_scan_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .TICK_CYCLES (TC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset_n  (Reset_n),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Mode     (Mode),
        .Step     (Step),
        .Clear    (Clear),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .RdValid  (RdValid),
        .Done     (Done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic tickn(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    initial begin
        tickn(2);
        chk("rst_addr",  32'(RdAddr),  0);
        chk("rst_data",  32'(RdData),  0);
        chk("rst_valid", 32'(RdValid), 0);
        chk("rst_done",  32'(Done),    0);
        Reset_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            WrEn = 1'b1; WrAddr = AW'(k); WrData = DW'(k);
            tick();
        end
        WrEn = 1'b0;

        // AUTO: first advance on the 5th edge (mode-change edge restarts the divider)
        Mode = 2'b00;
        for (int i = 1; i <= 33; i++) begin
            tick();
            chk("auto_addr", 32'(RdAddr), ((i - 1) / 4) % 8);
            if (i >= 2) chk("auto_data", 32'(RdData), ((i - 2) / 4) % 8);
            chk("auto_valid", 32'(RdValid), (i >= 6 && (i - 2) % 4 == 0) ? 1 : 0);
        end

        Mode = 2'b11; Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("sweep_clr_addr", 32'(RdAddr), 0);
        chk("sweep_clr_done", 32'(Done), 0);
        for (int i = 2; i <= 52; i++) begin
            tick();
            chk("sweep_addr", 32'(RdAddr), ((i - 1) / 4 > 7) ? 7 : (i - 1) / 4);
            chk("sweep_done", 32'(Done), (i >= 33) ? 1 : 0);
        end

        Mode = 2'b00;
        tick();
        chk("leave_sweep_done", 32'(Done), 0);
        chk("leave_sweep_addr", 32'(RdAddr), 7);
        tickn(3);
        chk("auto_hold7", 32'(RdAddr), 7);
        tick();
        chk("auto_wrap", 32'(RdAddr), 0);

        Mode = 2'b10; Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("step_clr", 32'(RdAddr), 0);
        for (int n = 1; n <= 3; n++) begin
            Step = 1'b1; tickn(2);
            Step = 1'b0; tickn(3);
            chk("step_addr", 32'(RdAddr), n);
            chk("step_data", 32'(RdData), n);
        end
        Step = 1'b1; tickn(10);
        Step = 1'b0; tickn(3);
        chk("step_held", 32'(RdAddr), 4);

        Mode = 2'b01; tick();
        Step = 1'b1; tickn(2);
        Step = 1'b0; tickn(3);
        Mode = 2'b10; tickn(4);
        chk("step_discard", 32'(RdAddr), 4);

        Step = 1'b1; tickn(2);
        Step = 1'b0; tickn(3);
        chk("step_to5", 32'(RdAddr), 5);

        WrEn = 1'b1; WrAddr = 3'd5; WrData = 3'd6;
        tick();
        WrEn = 1'b0;
        chk("rdw_bypass", 32'(RdData), 6);
        tick();
        chk("rdw_stored", 32'(RdData), 6);

        Mode = 2'b01; tickn(40);
        chk("pause_addr", 32'(RdAddr), 5);
        chk("pause_data", 32'(RdData), 6);

        Mode = 2'b00; Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("clr_addr", 32'(RdAddr), 0);
        chk("clr_valid_lat", 32'(RdValid), 0);
        tick();
        chk("clr_valid", 32'(RdValid), 1);
        tickn(14);
        chk("pre_clr_addr3", 32'(RdAddr), 3);
        // Divider is at its last count here: Clear collides with a tick
        Clear = 1'b1; WrEn = 1'b1; WrAddr = 3'd0; WrData = 3'd7;
        tick();
        Clear = 1'b0; WrEn = 1'b0;
        chk("clr_over_tick", 32'(RdAddr), 0);
        chk("clr_old_data", 32'(RdData), 3);
        tick();
        chk("clr_write_kept", 32'(RdData), 7);
        tickn(3);
        chk("post_clr_tick", 32'(RdAddr), 1);
        tick();
        chk("post_clr_valid", 32'(RdValid), 1);
        chk("post_clr_data", 32'(RdData), 1);

        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_addr",  32'(RdAddr),  0);
        chk("async_rst_data",  32'(RdData),  0);
        chk("async_rst_valid", 32'(RdValid), 0);
        chk("async_rst_done",  32'(Done),    0);
        tick();
        Reset_n = 1'b1;
        tickn(3);
        chk("post_rst_hold", 32'(RdAddr), 0);
        tick();
        chk("post_rst_tick", 32'(RdAddr), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
